// File: rtl/seq_det_pkg.sv
// Shared constants and configuration record for the serial pattern detector.
// Widths are sized for the largest legal pattern (32 bits).
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  localparam logic [31:0] DEF_PAT = 32'b10010;
  localparam logic [5:0]  DEF_LEN = 6'd5;
  localparam logic        DEF_OVL = 1'b1;

  typedef struct packed {
    logic [31:0] pat;
    logic [5:0]  len;
    logic        ovl;
  } cfg_t;

  localparam cfg_t CFG_DEF = '{pat: DEF_PAT, len: DEF_LEN, ovl: DEF_OVL};

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clr restarts the count at the current increment.
// One-edge update latency, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= {{(CNT_W-1){1'b0}}, inc};
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/moore_seq_detect_p.sv
// Configurable serial pattern detector with overlapping/non-overlapping modes.
// match is registered: high the cycle after the edge that took the last bit.
module moore_seq_detect_p
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         in_valid,
  input  logic                         din,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  cfg_t               r_cfg;
  logic               r_match;
  logic               r_cfg_err;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_pat;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_hit;
  logic               w_cfg_ok;
  logic               w_unused;

  assign w_pat    = r_cfg.pat[MAX_LEN-1:0];
  assign w_len    = r_cfg.len[LEN_W-1:0];
  assign w_cfg_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  // The oldest history bit is shifted out before it can ever be compared.
  assign w_unused = ^{r_cfg.pat, r_cfg.len, r_hist[MAX_LEN-1]};

  always_comb begin
    w_hist_n = {r_hist[MAX_LEN-2:0], din};
    w_fill_n = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    w_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(w_len));
    end
    w_hit = in_valid && !cfg_load && (w_fill_n >= w_len) &&
            (((w_hist_n ^ w_pat) & w_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_cfg     <= CFG_DEF;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (cfg_load) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      if (w_cfg_ok) begin
        r_cfg <= '{pat: 32'(cfg_pattern), len: 6'(cfg_len), ovl: cfg_overlap};
      end else begin
        r_cfg_err <= 1'b1;
      end
    end else if (in_valid) begin
      r_hist  <= w_hist_n;
      // Non-overlapping mode restarts the search after every hit.
      r_fill  <= (w_hit && !r_cfg.ovl) ? '0 : w_fill_n;
      r_match <= w_hit;
    end else begin
      r_match <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hit),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign match   = r_match;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_moore_seq_detect_p.sv
// Randomised and directed bench for moore_seq_detect_p against a bit-list model.
// A second instance with a 3-bit counter shares the stimulus to exercise saturation.
module tb_moore_seq_detect_p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       cnt_clr = 1'b0;

  logic        match, match3, cfg_err, cfg_err3;
  logic [15:0] match_count;
  logic [2:0]  match_count3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  moore_seq_detect_p u_dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .din(din),
    .cnt_clr(cnt_clr), .match(match), .match_count(match_count), .cfg_err(cfg_err)
  );

  moore_seq_detect_p #(.MAX_LEN(8), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .din(din),
    .cnt_clr(cnt_clr), .match(match3), .match_count(match_count3), .cfg_err(cfg_err3)
  );

  // Reference model: bits accepted since the last restart, newest at the back.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_match;
  bit         m_err;
  int         m_cnt;
  int         m_cnt3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_hit();
    int base;
    if (q.size() < m_len) return 1'b0;
    base = q.size() - m_len;
    for (int k = 0; k < m_len; k++) begin
      if (q[base + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cycle(input bit r, input bit ld, input logic [7:0] p, input int l,
                       input bit o, input bit vld, input bit d, input bit clr);
    bit hit;
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = 4'(l);
    cfg_overlap = o; in_valid = vld; din = d; cnt_clr = clr;
    @(posedge clk);
    hit = 1'b0;
    if (r) begin
      q.delete();
      m_pat = 8'b10010; m_len = 5; m_ovl = 1'b1;
      m_err = 1'b0; m_cnt = 0; m_cnt3 = 0;
    end else begin
      if (ld) begin
        q.delete();
        if (l >= 2 && l <= 8) begin
          m_pat = p; m_len = l; m_ovl = o;
        end else begin
          m_err = 1'b1;
        end
      end else if (vld) begin
        q.push_back(d);
        hit = model_hit();
        if (hit && !m_ovl) q.delete();
        while (q.size() > 8) void'(q.pop_front());
      end
      if (clr) begin
        m_cnt = int'(hit); m_cnt3 = int'(hit);
      end else begin
        m_cnt  = (m_cnt + int'(hit) > 65535) ? 65535 : m_cnt + int'(hit);
        m_cnt3 = (m_cnt3 + int'(hit) > 7) ? 7 : m_cnt3 + int'(hit);
      end
    end
    m_match = hit;
    #1;
    check("match", 32'(match), 32'(m_match));
    check("match_count", 32'(match_count), 32'(m_cnt));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    check("match_sat", 32'(match3), 32'(m_match));
    check("match_count_sat", 32'(match_count3), 32'(m_cnt3));
  endtask

  task automatic bit_in(input bit d);
    cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic gap();
    cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit o);
    cycle(1'b0, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  initial begin
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hff, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    check("reset_count", 32'(match_count), 32'd0);

    // Default pattern, overlapping.
    feed(32'b10010010, 8);
    check("default_two_hits", 32'(match_count), 32'd2);

    // 1010, non-overlapping then overlapping.
    load(8'b1010, 4, 1'b0);
    feed(32'b101010, 6);
    load(8'b1010, 4, 1'b1);
    feed(32'b101010, 6);

    // Illegal lengths keep the default pattern alive.
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    load(8'hff, 1, 1'b0);
    load(8'hff, 9, 1'b0);
    check("cfg_err_sticky", 32'(cfg_err), 32'd1);
    feed(32'b10010, 5);
    bit_in(1'b1); gap(); bit_in(1'b0); gap(); gap(); bit_in(1'b0);
    bit_in(1'b1); gap(); bit_in(1'b0);

    // Load on the edge of the final bit, then reset mid-sequence.
    feed(32'b1001, 4);
    cycle(1'b0, 1'b1, 8'b10010, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(32'b0010, 4);
    feed(32'b1001, 4);
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0);
    check("no_match_after_rst", 32'(match), 32'd0);

    // Nine overlapping hits, then clear coincident with a hit.
    feed(32'b10010, 5);
    for (int i = 0; i < 8; i++) feed(32'b010, 3);
    check("sat_at_7", 32'(match_count3), 32'd7);
    bit_in(1'b0); bit_in(1'b1);
    cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_with_hit", 32'(match_count), 32'd1);

    // Random traffic with occasional reconfiguration, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0)
        cycle(1'b1, 1'(r), '0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      else if (r < 6)
        cycle(1'b0, 1'b1, 8'($urandom), $urandom_range(0, 10), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      else
        cycle(1'b0, 1'b0, '0, 0, 1'b0, $urandom_range(0, 3) != 0, 1'($urandom),
              r < 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
